// File: rtl/muu_value_resp_mc.sv
// ============================================================================
// Module   : muu_value_resp_mc
// Function : Multi-channel value-response generator. Emits a header per
//            request, streams or drains the value, and splits into packets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muu_value_resp_mc #(
    parameter int DATA_WIDTH = 512,
    parameter int META_WIDTH = 96,
    parameter int LEN_WIDTH  = 10,
    parameter int NUM_CHAN   = 2,
    parameter int CHAN_BITS  = 1,
    parameter int MAX_WORDS  = 18
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [1+CHAN_BITS+LEN_WIDTH+META_WIDTH-1:0]   i_req_data,
    input  logic                                          i_req_valid,
    output logic                                          o_req_ready,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0]                i_val_data,
    input  logic [NUM_CHAN-1:0]                           i_val_valid,
    output logic [NUM_CHAN-1:0]                           o_val_ready,
    output logic [META_WIDTH+DATA_WIDTH-1:0]              o_out_data,
    output logic                                          o_out_valid,
    output logic                                          o_out_last,
    input  logic                                          i_out_ready,
    output logic [31:0]                                   o_stat_resp,
    output logic [31:0]                                   o_stat_drop
);

    localparam int c_W      = DATA_WIDTH / 64;
    localparam int c_BW     = LEN_WIDTH + 1;
    localparam int c_PKT_W  = $clog2(MAX_WORDS + 1);
    localparam int c_CB1    = CHAN_BITS + 1;

    localparam logic [c_BW-1:0]    c_W_M1     = c_BW'(c_W - 1);
    localparam logic [c_BW-1:0]    c_W_V      = c_BW'(c_W);
    localparam logic [c_BW-1:0]    c_ONE_BEAT = c_BW'(1);
    localparam logic [c_PKT_W-1:0] c_PKT_LAST = c_PKT_W'(MAX_WORDS - 1);
    localparam logic [c_CB1-1:0]   c_NCHAN    = c_CB1'(NUM_CHAN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_VALUE = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]                         r_state;
    logic [META_WIDTH-1:0]              r_meta;
    logic [CHAN_BITS-1:0]               r_chan;
    logic [c_BW-1:0]                    r_beats;
    logic [c_PKT_W-1:0]                 r_pkt_cnt;
    logic [META_WIDTH+DATA_WIDTH-1:0]   r_out_data;
    logic                               r_out_valid;
    logic                               r_out_last;
    logic [31:0]                        r_stat_resp;
    logic [31:0]                        r_stat_drop;

    logic [META_WIDTH-1:0]  w_req_meta;
    logic [LEN_WIDTH-1:0]   w_req_len;
    logic [CHAN_BITS-1:0]   w_req_chan;
    logic                   w_req_drop;
    logic [c_BW-1:0]        w_req_beats;
    logic                   w_chan_ok;
    logic                   w_beats_nz;
    logic                   w_hdr_last;
    logic [DATA_WIDTH-1:0]  w_hdr_beat;
    logic                   w_slot_free;
    logic                   w_req_fire;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_valid;
    logic                   w_val_fire;
    logic                   w_drop_fire;
    logic                   w_last_beat;
    logic                   w_pkt_full;

    assign w_req_meta  = i_req_data[META_WIDTH-1:0];
    assign w_req_len   = i_req_data[META_WIDTH +: LEN_WIDTH];
    assign w_req_chan  = i_req_data[META_WIDTH+LEN_WIDTH +: CHAN_BITS];
    assign w_req_drop  = i_req_data[META_WIDTH+LEN_WIDTH+CHAN_BITS];
    assign w_req_beats = ({1'b0, w_req_len} + c_W_M1) / c_W_V;
    assign w_chan_ok   = {1'b0, w_req_chan} < c_NCHAN;
    assign w_beats_nz  = (w_req_beats != '0);
    // Drops and bad channels never stream on the output, so their header closes the packet.
    assign w_hdr_last  = w_req_drop | !w_chan_ok | !w_beats_nz;

    always_comb begin
        w_hdr_beat        = '0;
        w_hdr_beat[15:0]  = w_chan_ok ? 16'hFFFF : 16'hFFFE;
        w_hdr_beat[31:16] = (w_req_drop || !w_chan_ok) ? 16'd0 : 16'(w_req_beats);
        w_hdr_beat[47:32] = 16'(w_req_len);
    end

    // The output slot frees when empty or when its beat leaves this cycle.
    assign w_slot_free = !r_out_valid | i_out_ready;
    assign o_req_ready = !rst && (r_state == S_IDLE) && w_slot_free;
    assign w_req_fire  = o_req_ready & i_req_valid;

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (r_chan == CHAN_BITS'(k)) begin
                w_sel_data  = i_val_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = i_val_valid[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_ready
        localparam logic [CHAN_BITS-1:0] c_K = CHAN_BITS'(k);
        assign o_val_ready[k] = !rst && (r_chan == c_K) &&
                                (((r_state == S_VALUE) && w_slot_free) || (r_state == S_DROP));
    end

    assign w_val_fire  = (r_state == S_VALUE) && w_slot_free && w_sel_valid;
    assign w_drop_fire = (r_state == S_DROP) && w_sel_valid;
    assign w_last_beat = (r_beats == c_ONE_BEAT);
    assign w_pkt_full  = (r_pkt_cnt == c_PKT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_meta      <= '0;
            r_chan      <= '0;
            r_beats     <= '0;
            r_pkt_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_stat_resp <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_req_fire) begin
                r_meta      <= w_req_meta;
                r_chan      <= w_req_chan;
                r_beats     <= w_req_beats;
                r_out_data  <= {w_req_meta, w_hdr_beat};
                r_out_valid <= 1'b1;
                r_out_last  <= w_hdr_last;
                r_pkt_cnt   <= w_hdr_last ? '0 : c_PKT_W'(1);
                r_stat_resp <= r_stat_resp + 32'd1;
                if (!w_chan_ok || !w_beats_nz) begin
                    r_state <= S_IDLE;
                end else if (w_req_drop) begin
                    r_state <= S_DROP;
                end else begin
                    r_state <= S_VALUE;
                end
            end else if (w_val_fire) begin
                r_out_data  <= {r_meta, w_sel_data};
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_beat | w_pkt_full;
                r_pkt_cnt   <= (w_last_beat | w_pkt_full) ? '0 : r_pkt_cnt + c_PKT_W'(1);
                r_beats     <= r_beats - c_ONE_BEAT;
                if (w_last_beat) begin
                    r_state <= S_IDLE;
                end
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_drop_fire) begin
                r_beats     <= r_beats - c_ONE_BEAT;
                r_stat_drop <= r_stat_drop + 32'd1;
                if (w_last_beat) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_stat_resp = r_stat_resp;
    assign o_stat_drop = r_stat_drop;

endmodule

`default_nettype wire

// File: tb/tb_muu_value_resp_mc.sv
// ============================================================================
// Module   : tb_muu_value_resp_mc
// Function : Directed self-checking bench for muu_value_resp_mc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muu_value_resp_mc;

    localparam int DW   = 512;
    localparam int MW   = 96;
    localparam int LW   = 10;
    localparam int NC   = 3;
    localparam int CB   = 2;
    localparam int MAXW = 18;
    localparam int RW   = 1 + CB + LW + MW;
    localparam int OW   = MW + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [RW-1:0]   req_data;
    logic            req_valid;
    logic            req_ready;
    logic [NC*DW-1:0] val_data;
    logic [NC-1:0]   val_valid;
    logic [NC-1:0]   val_ready;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic [31:0]     stat_resp;
    logic [31:0]     stat_drop;

    muu_value_resp_mc #(
        .DATA_WIDTH (DW),
        .META_WIDTH (MW),
        .LEN_WIDTH  (LW),
        .NUM_CHAN   (NC),
        .CHAN_BITS  (CB),
        .MAX_WORDS  (MAXW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_data  (req_data),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_val_data  (val_data),
        .i_val_valid (val_valid),
        .o_val_ready (val_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .o_out_last  (out_last),
        .i_out_ready (out_ready),
        .o_stat_resp (stat_resp),
        .o_stat_drop (stat_drop)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_beat [NC];
    int            src_idx  [NC];
    logic [OW-1:0] cap_data [$];
    logic          cap_last [$];
    int            cap_cyc  [$];
    int            cyc, acc_cyc;
    logic [NC-1:0] allowed;
    int            bad_ready, hold_err, vr_err;
    bit            rand_ready, chk_vr;
    int            n_cmp, n_fail;

    always_comb begin
        val_data = '0;
        for (int c = 0; c < NC; c++) val_data[c*DW +: DW] = src_beat[c];
    end

    function automatic logic [DW-1:0] pattern(input int c, input int idx);
        logic [DW-1:0] p;
        for (int i = 0; i < DW/32; i++) p[i*32 +: 32] = {8'hA5, 8'(c), 8'(idx), 8'(i)};
        return p;
    endfunction

    function automatic logic [OW-1:0] hdr(input logic [MW-1:0] meta, input logic [15:0] tag,
                                          input logic [15:0] beats, input logic [15:0] len);
        logic [OW-1:0] r;
        r = '0;
        r[63:0] = {16'h0, len, beats, tag};
        r[DW +: MW] = meta;
        return r;
    endfunction

    function automatic logic [RW-1:0] mkreq(input logic drop, input logic [CB-1:0] chan,
                                            input logic [LW-1:0] len, input logic [MW-1:0] meta);
        return {drop, chan, len, meta};
    endfunction

    // One clock: observe handshakes before the edge, update sources after it.
    task automatic tick();
        logic [NC-1:0] fire;
        logic          held, rf;
        logic [OW-1:0] held_d;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready) begin
            cap_data.push_back(out_data);
            cap_last.push_back(out_last);
            cap_cyc.push_back(cyc);
        end
        held   = (out_valid === 1'b1) && !out_ready;
        held_d = out_data;
        if (chk_vr && held && val_ready !== '0) vr_err++;
        if ((val_ready & ~allowed) != '0) bad_ready++;
        fire = val_valid & val_ready;
        rf   = req_valid & req_ready;
        if (rf) acc_cyc = cyc;
        @(posedge clk);
        cyc++;
        #1;
        if (held && !rst && (out_valid !== 1'b1 || out_data !== held_d)) hold_err++;
        for (int c = 0; c < NC; c++) begin
            if (fire[c]) begin
                src_idx[c]++;
                src_beat[c] = pattern(c, src_idx[c]);
            end
        end
        if (rf) req_valid = 1'b0;
        if (rand_ready) out_ready = ($urandom_range(0, 99) >= 40);
    endtask

    task automatic wait_caps(input int n, input int bound);
        int t;
        t = 0;
        while (cap_data.size() < n && t < bound) begin
            tick();
            t++;
        end
    endtask

    task automatic start(input logic [RW-1:0] rq, input logic [NC-1:0] allow);
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
        bad_ready = 0;
        allowed   = allow;
        req_data  = rq;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_data = '0; val_valid = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got %b want 0", out_last); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        n_cmp++; if (val_ready !== '0) begin n_fail++; $display("FAIL rst_val_ready got %b want 0", val_ready); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data); end
        n_cmp++; if (stat_resp !== 32'd0) begin n_fail++; $display("FAIL rst_stat_resp got %0d want 0", stat_resp); end
        n_cmp++; if (stat_drop !== 32'd0) begin n_fail++; $display("FAIL rst_stat_drop got %0d want 0", stat_drop); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
        val_valid = '1;
        out_ready = 1'b1;
    endtask

    task automatic test_zero_len();
        logic [MW-1:0] m;
        m = 96'h1111_2222_3333_4444_5555_6666;
        start(mkreq(1'b0, 2'd0, 10'd0, m), 3'b000);
        wait_caps(1, 20);
        repeat (3) tick();
        n_cmp++; if (cap_data.size() !== 1) begin n_fail++; $display("FAIL zl_count got %0d want 1", cap_data.size()); end
        n_cmp++; if (cap_data[0] !== hdr(m, 16'hFFFF, 16'd0, 16'd0)) begin n_fail++; $display("FAIL zl_hdr got %h want %h", cap_data[0], hdr(m, 16'hFFFF, 16'd0, 16'd0)); end
        n_cmp++; if (cap_last[0] !== 1'b1) begin n_fail++; $display("FAIL zl_last got %b want 1", cap_last[0]); end
        n_cmp++; if (cap_cyc[0] - acc_cyc !== 1) begin n_fail++; $display("FAIL zl_latency got %0d want 1", cap_cyc[0] - acc_cyc); end
        n_cmp++; if (stat_resp !== 32'd1) begin n_fail++; $display("FAIL zl_stat_resp got %0d want 1", stat_resp); end
        n_cmp++; if (bad_ready !== 0) begin n_fail++; $display("FAIL zl_no_ready got %0d want 0", bad_ready); end
    endtask

    task automatic test_chan1();
        logic [MW-1:0] m;
        int s0, s1, s2;
        m = 96'hCAFE_0001_0002_0003_0004_0005;
        s0 = src_idx[0]; s1 = src_idx[1]; s2 = src_idx[2];
        start(mkreq(1'b0, 2'd1, 10'd20, m), 3'b010);
        wait_caps(4, 40);
        repeat (3) tick();
        n_cmp++; if (cap_data.size() !== 4) begin n_fail++; $display("FAIL c1_count got %0d want 4", cap_data.size()); end
        n_cmp++; if (cap_data[0] !== hdr(m, 16'hFFFF, 16'd3, 16'd20)) begin n_fail++; $display("FAIL c1_hdr got %h want %h", cap_data[0], hdr(m, 16'hFFFF, 16'd3, 16'd20)); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cap_last[i] !== (i == 3)) begin n_fail++; $display("FAIL c1_last[%0d] got %b want %b", i, cap_last[i], (i == 3)); end
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (cap_data[i] !== {m, pattern(1, s1 + i - 1)}) begin n_fail++; $display("FAIL c1_beat[%0d] got %h want %h", i, cap_data[i], {m, pattern(1, s1 + i - 1)}); end
        end
        n_cmp++; if (cap_cyc[3] - cap_cyc[0] !== 3) begin n_fail++; $display("FAIL c1_rate got %0d want 3", cap_cyc[3] - cap_cyc[0]); end
        n_cmp++; if (bad_ready !== 0) begin n_fail++; $display("FAIL c1_unsel_ready got %0d want 0", bad_ready); end
        n_cmp++; if (src_idx[0] !== s0 || src_idx[2] !== s2) begin n_fail++; $display("FAIL c1_unsel_consumed got %0d/%0d want %0d/%0d", src_idx[0], src_idx[2], s0, s2); end
        n_cmp++; if (src_idx[1] !== s1 + 3) begin n_fail++; $display("FAIL c1_consumed got %0d want %0d", src_idx[1], s1 + 3); end
        n_cmp++; if (stat_resp !== 32'd2) begin n_fail++; $display("FAIL c1_stat_resp got %0d want 2", stat_resp); end
    endtask

    task automatic test_packetise();
        logic [MW-1:0] m;
        int s0;
        m = 96'hBEEF_1234_5678_9ABC_DEF0_0F0F;
        s0 = src_idx[0];
        start(mkreq(1'b0, 2'd0, 10'd160, m), 3'b001);
        wait_caps(21, 80);
        repeat (3) tick();
        n_cmp++; if (cap_data.size() !== 21) begin n_fail++; $display("FAIL pk_count got %0d want 21", cap_data.size()); end
        n_cmp++; if (cap_data[0] !== hdr(m, 16'hFFFF, 16'd20, 16'd160)) begin n_fail++; $display("FAIL pk_hdr got %h want %h", cap_data[0], hdr(m, 16'hFFFF, 16'd20, 16'd160)); end
        for (int i = 1; i < 21; i++) begin
            n_cmp++; if (cap_data[i] !== {m, pattern(0, s0 + i - 1)}) begin n_fail++; $display("FAIL pk_beat[%0d] got %h want %h", i, cap_data[i], {m, pattern(0, s0 + i - 1)}); end
        end
        for (int i = 0; i < 21; i++) begin
            n_cmp++; if (cap_last[i] !== (i == 17 || i == 20)) begin n_fail++; $display("FAIL pk_last[%0d] got %b want %b", i, cap_last[i], (i == 17 || i == 20)); end
        end
        n_cmp++; if (cap_cyc[20] - cap_cyc[0] !== 20) begin n_fail++; $display("FAIL pk_rate got %0d want 20", cap_cyc[20] - cap_cyc[0]); end
        n_cmp++; if (stat_resp !== 32'd3) begin n_fail++; $display("FAIL pk_stat_resp got %0d want 3", stat_resp); end
    endtask

    task automatic test_drop();
        logic [MW-1:0] m;
        int s0;
        m = 96'hD0D0_0000_1111_2222_3333_4444;
        s0 = src_idx[0];
        out_ready = 1'b0;
        start(mkreq(1'b1, 2'd0, 10'd16, m), 3'b001);
        repeat (6) tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dr_valid got %b want 1", out_valid); end
        n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL dr_last got %b want 1", out_last); end
        n_cmp++; if (out_data !== hdr(m, 16'hFFFF, 16'd0, 16'd16)) begin n_fail++; $display("FAIL dr_hdr got %h want %h", out_data, hdr(m, 16'hFFFF, 16'd0, 16'd16)); end
        n_cmp++; if (src_idx[0] !== s0 + 2) begin n_fail++; $display("FAIL dr_consumed got %0d want %0d", src_idx[0], s0 + 2); end
        n_cmp++; if (stat_drop !== 32'd2) begin n_fail++; $display("FAIL dr_stat_drop got %0d want 2", stat_drop); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL dr_req_blocked got %b want 0", req_ready); end
        out_ready = 1'b1;
        wait_caps(1, 10);
        repeat (3) tick();
        n_cmp++; if (cap_data.size() !== 1) begin n_fail++; $display("FAIL dr_count got %0d want 1", cap_data.size()); end
        n_cmp++; if (stat_resp !== 32'd4) begin n_fail++; $display("FAIL dr_stat_resp got %0d want 4", stat_resp); end
    endtask

    task automatic test_backpressure();
        logic [MW-1:0] m;
        int s2;
        m = 96'h5555_AAAA_5555_AAAA_5555_AAAA;
        s2 = src_idx[2];
        hold_err = 0; vr_err = 0; chk_vr = 1'b1; rand_ready = 1'b1;
        start(mkreq(1'b0, 2'd2, 10'd64, m), 3'b100);
        wait_caps(9, 300);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk_vr = 1'b0;
        n_cmp++; if (cap_data.size() !== 9) begin n_fail++; $display("FAIL bp_count got %0d want 9", cap_data.size()); end
        n_cmp++; if (cap_data[0] !== hdr(m, 16'hFFFF, 16'd8, 16'd64)) begin n_fail++; $display("FAIL bp_hdr got %h want %h", cap_data[0], hdr(m, 16'hFFFF, 16'd8, 16'd64)); end
        for (int i = 1; i < 9; i++) begin
            n_cmp++; if (cap_data[i] !== {m, pattern(2, s2 + i - 1)}) begin n_fail++; $display("FAIL bp_beat[%0d] got %h want %h", i, cap_data[i], {m, pattern(2, s2 + i - 1)}); end
            n_cmp++; if (cap_last[i] !== (i == 8)) begin n_fail++; $display("FAIL bp_last[%0d] got %b want %b", i, cap_last[i], (i == 8)); end
        end
        n_cmp++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_hold got %0d want 0", hold_err); end
        n_cmp++; if (vr_err !== 0) begin n_fail++; $display("FAIL bp_val_ready_stall got %0d want 0", vr_err); end
        n_cmp++; if (bad_ready !== 0) begin n_fail++; $display("FAIL bp_unsel_ready got %0d want 0", bad_ready); end
    endtask

    task automatic test_bad_chan();
        logic [MW-1:0] m;
        int s0, s1, s2;
        m = 96'hBAD0_CAFE_0000_0000_0000_0003;
        s0 = src_idx[0]; s1 = src_idx[1]; s2 = src_idx[2];
        start(mkreq(1'b0, 2'd3, 10'd16, m), 3'b000);
        wait_caps(1, 20);
        repeat (4) tick();
        n_cmp++; if (cap_data.size() !== 1) begin n_fail++; $display("FAIL bc_count got %0d want 1", cap_data.size()); end
        n_cmp++; if (cap_data[0] !== hdr(m, 16'hFFFE, 16'd0, 16'd16)) begin n_fail++; $display("FAIL bc_hdr got %h want %h", cap_data[0], hdr(m, 16'hFFFE, 16'd0, 16'd16)); end
        n_cmp++; if (cap_last[0] !== 1'b1) begin n_fail++; $display("FAIL bc_last got %b want 1", cap_last[0]); end
        n_cmp++; if (bad_ready !== 0) begin n_fail++; $display("FAIL bc_ready got %0d want 0", bad_ready); end
        n_cmp++; if (src_idx[0] !== s0 || src_idx[1] !== s1 || src_idx[2] !== s2) begin n_fail++; $display("FAIL bc_consumed got %0d/%0d/%0d want %0d/%0d/%0d", src_idx[0], src_idx[1], src_idx[2], s0, s1, s2); end
        n_cmp++; if (stat_resp !== 32'd6) begin n_fail++; $display("FAIL bc_stat_resp got %0d want 6", stat_resp); end
    endtask

    task automatic test_reset_mid();
        int s0, n;
        start(mkreq(1'b0, 2'd0, 10'd160, 96'h7777_0000_0000_0000_0000_0007), 3'b001);
        wait_caps(5, 20);
        s0 = src_idx[0];
        rst = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid got %b want 0", out_valid); end
        n_cmp++; if (val_ready !== '0) begin n_fail++; $display("FAIL rm_val_ready got %b want 0", val_ready); end
        n_cmp++; if (src_idx[0] !== s0) begin n_fail++; $display("FAIL rm_consumed got %0d want %0d", src_idx[0], s0); end
        rst = 1'b0;
        n = cap_data.size();
        repeat (4) tick();
        n_cmp++; if (cap_data.size() !== n) begin n_fail++; $display("FAIL rm_no_output got %0d want %0d", cap_data.size(), n); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_idle got %b want 1", req_ready); end
        n_cmp++; if (stat_resp !== 32'd0) begin n_fail++; $display("FAIL rm_stat_resp got %0d want 0", stat_resp); end
        n_cmp++; if (src_idx[0] !== s0) begin n_fail++; $display("FAIL rm_no_consume got %0d want %0d", src_idx[0], s0); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; acc_cyc = 0;
        bad_ready = 0; hold_err = 0; vr_err = 0;
        rand_ready = 1'b0; chk_vr = 1'b0; allowed = '0;
        for (int c = 0; c < NC; c++) begin
            src_idx[c]  = 0;
            src_beat[c] = pattern(c, 0);
        end
        test_reset();
        test_zero_len();
        test_chan1();
        test_packetise();
        test_drop();
        test_backpressure();
        test_bad_chan();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
